// File: rtl/ahb2_sram_slv_if.sv
// AHB2 slave-side bus bundle for ahb2_sram_slv.
// The master modport is what an upstream bus/decoder drives; the slave modport is the SRAM slave.
interface ahb2_sram_slv_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hreadyi;
  logic [31:0] hrdata;
  logic        hreadyo;
  logic [1:0]  hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hreadyi,
    input  hrdata, hreadyo, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hreadyi,
    output hrdata, hreadyo, hresp
  );
endinterface

// File: rtl/ahb2_sram_slv.sv
// AHB2 slave fronting a single-port synchronous SRAM (1-cycle read latency).
// A one-entry write buffer gives zero-wait writes and reads; the only stall is a read address
// phase arriving while an older buffered write is still pending during a write data phase.
// Bad size/alignment/range gets the two-cycle ERROR response.
// Optional: define AHB2_SRAM_HPROT_CHK_EN to reject user-mode (hprot[1]=0) transfers with ERROR.
module ahb2_sram_slv #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              hclk,
  input  logic              hreset_n,
  ahb2_sram_slv_if.slave    bus,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [3:0]        sram_be,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  localparam logic [1:0] RespOkay  = 2'b00;
  localparam logic [1:0] RespError = 2'b01;

  typedef enum logic [1:0] {StIdle, StErr1, StErr2} state_e;

  state_e            state_q;
  logic              err_wait_q, err_resp_q;

  logic              accept, addr_err, prot_err, req_ok, req_err, rd_issue;
  logic              hazard, wr_done, commit, buf_hit;
  logic [3:0]        req_be;
  logic [ADDR_W-1:0] req_addr;

  logic              dph_rd_q, dph_wr_q;
  logic [ADDR_W-1:0] dph_addr_q;
  logic [3:0]        dph_be_q;

  logic              buf_valid_q;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [3:0]        buf_be_q;
  logic [31:0]       buf_data_q;

  logic              unused_bus;
  assign unused_bus = ^{bus.hburst, bus.hprot, bus.htrans[0]};

  // No new address phase is taken while the first ERROR cycle is on the bus.
  assign accept   = hreset_n & bus.hsel & bus.hreadyi & bus.htrans[1] & (state_q != StErr1);
  assign req_addr = bus.haddr[ADDR_W+1:2];

  // Size/alignment/range decode and little-endian byte enables.
  always_comb begin
    addr_err = 1'b0;
    req_be   = 4'b0000;
    case (bus.hsize)
      3'd0: req_be = 4'b0001 << bus.haddr[1:0];
      3'd1: begin
        req_be   = 4'b0011 << bus.haddr[1:0];
        addr_err = bus.haddr[0];
      end
      3'd2: begin
        req_be   = 4'b1111;
        addr_err = |bus.haddr[1:0];
      end
      default: addr_err = 1'b1;
    endcase
    if (|bus.haddr[31:ADDR_W+2]) addr_err = 1'b1;
  end

`ifdef AHB2_SRAM_HPROT_CHK_EN
  assign prot_err = ~bus.hprot[1];
`else
  assign prot_err = 1'b0;
`endif

  assign req_ok   = accept & ~addr_err & ~prot_err;
  assign req_err  = accept & (addr_err | prot_err);
  assign rd_issue = req_ok & ~bus.hwrite;

  // Independent of hreadyi so that hreadyi = hreadyo never closes a combinational loop.
  assign hazard = hreset_n & dph_wr_q & buf_valid_q & bus.hsel & bus.htrans[1] & ~bus.hwrite;

  assign bus.hreadyo = ~err_wait_q & ~hazard;
  assign bus.hresp   = err_resp_q ? RespError : RespOkay;

  assign wr_done = dph_wr_q & bus.hreadyo;
  // Reads own the SRAM port; the buffer drains in any other cycle. Gated so reset discards it.
  assign commit  = hreset_n & buf_valid_q & ~rd_issue;
  assign buf_hit = buf_valid_q & (buf_addr_q == dph_addr_q);

  // SRAM port: read issue in the address phase has priority over draining the buffer.
  always_comb begin
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_be    = 4'b0000;
    sram_wdata = 32'h0;
    if (rd_issue) begin
      sram_cs   = 1'b1;
      sram_addr = req_addr;
      sram_be   = req_be;
    end else if (commit) begin
      sram_cs    = 1'b1;
      sram_we    = 1'b1;
      sram_addr  = buf_addr_q;
      sram_be    = buf_be_q;
      sram_wdata = buf_data_q;
    end
  end

  // Read data: SRAM word with lanes overridden by a matching, not-yet-committed buffered write.
  always_comb begin
    bus.hrdata = 32'h0;
    if (dph_rd_q) begin
      for (int n = 0; n < 4; n++) begin
        bus.hrdata[8*n +: 8] = (buf_hit && buf_be_q[n]) ? buf_data_q[8*n +: 8]
                                                        : sram_rdata[8*n +: 8];
      end
    end
  end

  // Data-phase tracking; holds while the bus is stalled.
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      dph_rd_q   <= 1'b0;
      dph_wr_q   <= 1'b0;
      dph_addr_q <= '0;
      dph_be_q   <= 4'b0000;
    end else if (bus.hreadyi) begin
      dph_rd_q <= rd_issue;
      dph_wr_q <= req_ok & bus.hwrite;
      if (req_ok) begin
        dph_addr_q <= req_addr;
        dph_be_q   <= req_be;
      end
    end
  end

  // Write buffer: filled at the end of a write data phase, cleared when drained to SRAM.
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_be_q    <= 4'b0000;
      buf_data_q  <= 32'h0;
    end else if (wr_done) begin
      buf_valid_q <= 1'b1;
      buf_addr_q  <= dph_addr_q;
      buf_be_q    <= dph_be_q;
      buf_data_q  <= bus.hwdata;
    end else if (commit) begin
      buf_valid_q <= 1'b0;
    end
  end

  // Two-cycle ERROR response FSM with registered hreadyo/hresp controls.
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      state_q    <= StIdle;
      err_wait_q <= 1'b0;
      err_resp_q <= 1'b0;
    end else begin
      case (state_q)
        StErr1: begin
          state_q    <= StErr2;
          err_wait_q <= 1'b0;
          err_resp_q <= 1'b1;
        end
        default: begin
          if (req_err) begin
            state_q    <= StErr1;
            err_wait_q <= 1'b1;
            err_resp_q <= 1'b1;
          end else begin
            state_q    <= StIdle;
            err_wait_q <= 1'b0;
            err_resp_q <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb2_sram_slv.sv
// Scoreboard bench for ahb2_sram_slv: directed transfer lists are driven as a pipelined AHB2
// master, expectations come from a byte-level reference memory and are queued at acceptance.
module tb_ahb2_sram_slv;
  localparam int unsigned AddrW = 10;
  localparam int unsigned Words = 1 << AddrW;

  logic             hclk;
  logic             hreset_n;
  logic             sram_cs, sram_we;
  logic [AddrW-1:0] sram_addr;
  logic [3:0]       sram_be;
  logic [31:0]      sram_wdata, sram_rdata;
  logic             mem_init;

  ahb2_sram_slv_if bus ();
  assign bus.hreadyi = bus.hreadyo;

  ahb2_sram_slv #(.ADDR_W(AddrW)) dut (
    .hclk       (hclk),
    .hreset_n   (hreset_n),
    .bus        (bus),
    .sram_cs    (sram_cs),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_be    (sram_be),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h0F0F_0000;
  endfunction

  // Synchronous SRAM device
  logic [31:0] sram_mem [Words];
  always @(posedge hclk) begin
    if (mem_init) begin
      for (int i = 0; i < int'(Words); i++) sram_mem[i] <= init_word(i);
    end else if (sram_cs) begin
      if (sram_we) begin
        for (int k = 0; k < 4; k++)
          if (sram_be[k]) sram_mem[sram_addr][8*k +: 8] <= sram_wdata[8*k +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  prot;
    logic [31:0] wdata;
    int          exp_wait;
  } xfer_t;

  typedef struct {
    logic        wr;
    logic        err;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          exp_wait;
  } exp_t;

  xfer_t       seq[$];
  exp_t        sb[$];
  logic [7:0]  ref_mem [4*Words];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cs_cnt = 0;
  logic [3:0]  last_be = 4'h0;
  logic [31:0] last_addr = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  function automatic logic bench_err(input xfer_t x);
    logic e;
    e = (x.size > 3'd2) || (x.size == 3'd1 && x.addr[0]) ||
        (x.size == 3'd2 && x.addr[1:0] != 2'b00) || (x.addr[31:AddrW+2] != 0);
`ifdef AHB2_SRAM_HPROT_CHK_EN
    e = e || !x.prot[1];
`endif
    return e;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = 4 * int'(a[AddrW+1:2]);
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  task automatic ref_write(input xfer_t x);
    int b, lane, nb;
    b  = 4 * int'(x.addr[AddrW+1:2]);
    nb = 1 << int'(x.size);
    for (int k = 0; k < nb; k++) begin
      lane = (int'(x.addr[1:0]) + k) % 4;
      ref_mem[b + lane] = x.wdata[8*lane +: 8];
    end
  endtask

  task automatic add(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                     input logic [31:0] wdata, input int exp_wait = 0,
                     input logic [3:0] prot = 4'b0011);
    xfer_t x;
    x.wr = wr; x.addr = addr; x.size = size; x.prot = prot; x.wdata = wdata;
    x.exp_wait = exp_wait;
    seq.push_back(x);
  endtask

  task automatic sample_sram();
    if (sram_cs) begin
      cs_cnt++;
      if (sram_we) begin
        last_be   = sram_be;
        last_addr = 32'(sram_addr);
      end
    end
  endtask

  task automatic bus_idle();
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwrite = 1'b0; bus.haddr = 32'h0;
    bus.hsize = 3'd0; bus.hburst = 3'd0; bus.hprot = 4'b0011; bus.hwdata = 32'h0;
  endtask

  // Entered and left at posedge+1.
  task automatic idle(input int n);
    bus_idle();
    repeat (n) begin
      @(negedge hclk);
      sample_sram();
      check("idle_hrdata", bus.hrdata, 32'h0);
      @(posedge hclk); #1;
    end
  endtask

  // Drives seq as back-to-back NONSEQ transfers; entered and left at posedge+1.
  task automatic run_seq(input string name);
    int    idx = 0;
    int    waits = 0;
    int    guard = 0;
    exp_t  e;
    xfer_t x;
    while ((idx < seq.size() || sb.size() > 0) && guard < 100) begin
      guard++;
      if (idx < seq.size()) begin
        x = seq[idx];
        bus.hsel = 1'b1; bus.htrans = 2'b10; bus.hwrite = x.wr; bus.haddr = x.addr;
        bus.hsize = x.size; bus.hprot = x.prot; bus.hburst = 3'b001;
      end else begin
        bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwrite = 1'b0; bus.haddr = 32'h0;
      end
      bus.hwdata = (sb.size() > 0 && sb[0].wr) ? sb[0].wdata : 32'h0;
      @(negedge hclk);
      sample_sram();
      if (sb.size() > 0) begin
        if (!bus.hreadyo) begin
          waits++;
          check({name, " stall_hresp"}, 32'(bus.hresp), sb[0].err ? 32'd1 : 32'd0);
        end else begin
          e = sb.pop_front();
          check({name, " hresp"}, 32'(bus.hresp), e.err ? 32'd1 : 32'd0);
          check({name, " waits"}, 32'(waits), 32'(e.exp_wait));
          if (!e.wr && !e.err) check({name, " hrdata"}, bus.hrdata, e.rdata);
          else check({name, " hrdata_zero"}, bus.hrdata, 32'h0);
          waits = 0;
        end
      end else begin
        check({name, " ready_no_dph"}, 32'(bus.hreadyo), 32'd1);
      end
      if (bus.hreadyo && idx < seq.size()) begin
        e.wr = x.wr; e.err = bench_err(x); e.wdata = x.wdata; e.rdata = 32'h0;
        e.exp_wait = e.err ? 1 : x.exp_wait;
        if (!e.err) begin
          if (x.wr) ref_write(x);
          else e.rdata = ref_word(x.addr);
        end
        sb.push_back(e);
        idx++;
      end
      @(posedge hclk); #1;
    end
    if (guard >= 100) begin
      check({name, " timeout"}, 32'd0, 32'd1);
      sb.delete();
    end
    seq.delete();
  endtask

  int c0;

  initial begin
    hreset_n = 1'b0;
    mem_init = 1'b1;
    bus_idle();
    for (int i = 0; i < int'(Words); i++) begin
      for (int k = 0; k < 4; k++) ref_mem[4*i + k] = init_word(i)[8*k +: 8];
    end

    // Reset state
    repeat (2) @(posedge hclk);
    #1 mem_init = 1'b0;
    @(negedge hclk);
    check("rst hreadyo", 32'(bus.hreadyo), 32'd1);
    check("rst hresp", 32'(bus.hresp), 32'd0);
    check("rst hrdata", bus.hrdata, 32'h0);
    check("rst sram_cs", 32'(sram_cs), 32'd0);
    check("rst sram_we", 32'(sram_we), 32'd0);
    check("rst sram_addr", 32'(sram_addr), 32'd0);
    check("rst sram_be", 32'(sram_be), 32'd0);
    check("rst sram_wdata", sram_wdata, 32'h0);
    @(posedge hclk); #1;
    hreset_n = 1'b1;
    idle(2);

    // Write then read back-to-back: data forwarded from the buffer
    add(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF);
    add(1'b0, 32'h10, 3'd2, 32'h0);
    run_seq("fwd");
    idle(2);

    // Byte write on lane 3 over an existing word
    add(1'b1, 32'h10, 3'd2, 32'h1122_3344);
    add(1'b1, 32'h13, 3'd0, 32'hAA00_0000);
    run_seq("byte_wr");
    idle(3);
    check("byte_wr commit_be", 32'(last_be), 32'h8);
    check("byte_wr commit_addr", last_addr, 32'h4);
    add(1'b0, 32'h10, 3'd2, 32'h0);
    run_seq("byte_rd");
    idle(2);

    // Hazard: read behind two writes stalls the second write data phase once
    add(1'b1, 32'h20, 3'd2, 32'h0102_0304);
    add(1'b1, 32'h24, 3'd2, 32'hA5A5_5A5A, 1);
    add(1'b0, 32'h24, 3'd2, 32'h0);
    add(1'b0, 32'h20, 3'd2, 32'h0);
    run_seq("hazard");
    idle(2);

    // Error responses, none of which may touch the SRAM
    c0 = cs_cnt;
    add(1'b1, 32'h02, 3'd2, 32'h1234_5678);
    add(1'b0, 32'h4000, 3'd2, 32'h0);
    add(1'b0, 32'h07, 3'd3, 32'h0);
    add(1'b1, 32'h01, 3'd1, 32'h0000_FFFF);
    run_seq("err");
    check("err sram_cs_count", 32'(cs_cnt - c0), 32'd0);
    idle(2);

    // User-mode write: rejected only when the protection check is built in
    add(1'b1, 32'h30, 3'd2, 32'h7766_5544, 0, 4'b0001);
    add(1'b0, 32'h30, 3'd2, 32'h0);
    run_seq("hprot");
    idle(2);

    // Halfword/byte lanes and reads of untouched words
    add(1'b1, 32'h52, 3'd1, 32'hBEEF_0000);
    add(1'b0, 32'h50, 3'd2, 32'h0);
    add(1'b1, 32'h61, 3'd0, 32'h0000_3C00);
    add(1'b0, 32'h104, 3'd2, 32'h0);
    add(1'b0, 32'h60, 3'd2, 32'h0);
    add(1'b0, 32'h50, 3'd0, 32'h0);
    run_seq("mixed");
    idle(2);

    // Reset with a write still in the buffer: the write is lost
    add(1'b1, 32'h40, 3'd2, 32'hCAFE_F00D);
    run_seq("rst_mid_wr");
    hreset_n = 1'b0;
    @(negedge hclk);
    check("rst_mid sram_cs", 32'(sram_cs), 32'd0);
    @(posedge hclk); #1;
    @(posedge hclk); #1;
    hreset_n = 1'b1;
    for (int k = 0; k < 4; k++) ref_mem[16*4 + k] = init_word(16)[8*k +: 8];
    idle(2);
    add(1'b0, 32'h40, 3'd2, 32'h0);
    run_seq("rst_mid_rd");
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ahb2_sram_slv.md
# ahb2_sram_slv

AHB2 slave that turns transfers from the slave-side AHB2 bus (hsel/hreadyi/hreadyo signal set) into accesses on a single-port synchronous SRAM with 1-cycle read latency. It sits directly downstream of the AHB2 slave interface, after the address decoder, and serves as the on-chip scratch memory. A one-entry write buffer lets writes, reads and back-to-back transfers complete with zero wait states except in one documented hazard case. Unaligned, oversized and out-of-range accesses get the two-cycle ERROR response.

## Interface
- ADDR_W, 10, SRAM word-address width; memory size 4·2^ADDR_W bytes
- hclk  input  1  bus clock; all logic on rising edge
- hreset_n  input  1  reset, synchronous, active-low
- hsel  input  1  slave select from decoder
- haddr  input  32  byte address
- htrans  input  2  IDLE/BUSY/NONSEQ/SEQ
- hwrite  input  1  1 = write
- hsize  input  3  transfer size
- hburst  input  3  burst type; informational only, ignored
- hprot  input  4  protection attributes
- hwdata  input  32  write data, valid in data phase
- hreadyi  input  1  bus-level ready; address phase accepted only when high
- hrdata  output  32  read data
- hreadyo  output  1  this slave's ready
- hresp  output  2  OKAY or ERROR only; RETRY/SPLIT never driven
- sram_cs  output  1  SRAM access enable
- sram_we  output  1  1 = write
- sram_addr  output  ADDR_W  word address
- sram_be  output  4  byte enables, bit n = byte lane n
- sram_wdata  output  32  write data
- sram_rdata  input  32  read data, valid the cycle after sram_cs & !sram_we

## Operation
- Accepted transfer: hsel & hreadyi & htrans[1] at rising edge. IDLE/BUSY/unselected: OKAY, zero wait.
- Address checks at acceptance -> ERROR if any: hsize > HSIZE_32BITS; hsize 16-bit with haddr[0]=1; hsize 32-bit with haddr[1:0]≠0; haddr[31:ADDR_W+2]≠0.
- Byte enables, little-endian: 8-bit -> 1<<haddr[1:0]; 16-bit -> 4'b0011<<haddr[1:0]; 32-bit -> 4'b1111.
- Word address = haddr[ADDR_W+1:2].
- Reads: SRAM read issued in accepted address phase (sram_cs=1, sram_we=0). Data phase: hrdata = sram_rdata with lanes replaced by buffer bytes where buffer valid, addresses match and buffer be set. Non-read-data cycles: hrdata=0.
- Writes: address/be captured at acceptance; hwdata captured into buffer at end of data phase; buf_valid=1.
- Commit: buffer written to SRAM in any cycle with buf_valid=1 and no accepted read address phase; buf_valid clears on that edge unless refilled on the same edge.
- Hazard: buf_valid=1, write data phase in progress, read address phase presented -> hreadyo=0 one cycle, buffer commits, then hreadyo=1; read issued when accepted.
- Error FSM: IDLE -> ERR1 (hreadyo=0, hresp=ERROR) -> ERR2 (hreadyo=1, hresp=ERROR) -> IDLE. Erroneous write never enters buffer; address presented during ERR1 not accepted.
- Reset mid-operation: pending buffered write discarded, FSM to IDLE.

## Timing
- Reset values: hreadyo=1, hresp=OKAY, hrdata=0, sram_cs=0, sram_we=0, sram_addr=0, sram_be=0, sram_wdata=0, buf_valid=0, FSM IDLE.
- Read latency: data phase = cycle after address phase, zero wait.
- Write: zero wait; SRAM commit ≥1 cycle after data phase.
- Hazard stall: exactly 1 wait state in the write data phase.
- Error: exactly 2 data-phase cycles.

## Configuration
- AHB2_SRAM_HPROT_CHK_EN defined: accepted transfer with hprot[1]=0 (user) gets ERROR; no SRAM access, buffer untouched.
- Undefined: hprot ignored entirely.

## Test plan
- Reset: hreset_n=0 two cycles -> all outputs at reset values, hreadyo=1.
- 32-bit write 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> read data phase hrdata=0xDEADBEEF via buffer forward, zero wait.
- Byte write 0xAA to 0x13 over SRAM word 0x11223344 -> sram_be=4'b1000, later read 0x10 returns 0xAA223344.
- Write 0x20, write 0x24, read 0x24 back-to-back -> one hreadyo=0 cycle in second write data phase; read returns second write data.
- 32-bit access to 0x02, then access to 0x4000 with ADDR_W=10 -> each ERR1 then ERR2 with hresp=ERROR, no sram_cs.
- With AHB2_SRAM_HPROT_CHK_EN, write with hprot=4'b0001 -> ERROR two cycles, SRAM contents unchanged.
